input_router_xy_vc: RTL and testbench

//  Parametrised per-input-port route computation for the mesh NoC router; successor to the fixed 3-entry router.

---
 rtl/input_router_xy_vc_if.sv | 33 +++
 rtl/input_router_xy_vc.sv | 140 ++++++++++++++
 tb/tb_input_router_xy_vc.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/input_router_xy_vc_if.sv
// Flit-in / route-request-out bundle for one router input port.
interface input_router_xy_vc_if #(
    parameter int unsigned X_W  = 2,
    parameter int unsigned Y_W  = 2,
    parameter int unsigned N_VC = 2
);
    localparam int unsigned VC_W = (N_VC > 1) ? $clog2(N_VC) : 1;

    logic            flit_valid_i;
    logic            flit_ready_o;
    logic [1:0]      flit_type_i;
    logic [VC_W-1:0] flit_vc_i;
    logic [X_W-1:0]  flit_x_dst_i;
    logic [Y_W-1:0]  flit_y_dst_i;
    logic            route_valid_o;
    logic            route_ready_i;
    logic [4:0]      router_port_o;
    logic [VC_W-1:0] route_vc_o;
    logic            route_err_o;
    logic [N_VC-1:0] vc_busy_o;

    // Router side
    modport slave (
        input  flit_valid_i, flit_type_i, flit_vc_i, flit_x_dst_i, flit_y_dst_i, route_ready_i,
        output flit_ready_o, route_valid_o, router_port_o, route_vc_o, route_err_o, vc_busy_o
    );

    // Upstream flit source / downstream allocator side
    modport master (
        output flit_valid_i, flit_type_i, flit_vc_i, flit_x_dst_i, flit_y_dst_i, route_ready_i,
        input  flit_ready_o, route_valid_o, router_port_o, route_vc_o, route_err_o, vc_busy_o
    );
endinterface

// File: rtl/input_router_xy_vc.sv
// Per-input-port XY route computation with per-VC packet tracking and a
// single registered valid/ready output stage toward the switch allocator.
module input_router_xy_vc #(
    parameter int unsigned X_W     = 2,
    parameter int unsigned Y_W     = 2,
    parameter int unsigned N_VC    = 2,
    parameter int unsigned LOCAL_X = 0,
    parameter int unsigned LOCAL_Y = 0
) (
    input logic                  clk,
    input logic                  arst,
    input_router_xy_vc_if.slave  bus
);
    localparam int unsigned VC_W = (N_VC > 1) ? $clog2(N_VC) : 1;

    localparam logic [4:0] P_LOCAL = 5'b00001;
    localparam logic [4:0] P_NORTH = 5'b00010;
    localparam logic [4:0] P_SOUTH = 5'b00100;
    localparam logic [4:0] P_WEST  = 5'b01000;
    localparam logic [4:0] P_EAST  = 5'b10000;

    typedef enum logic [1:0] {
        FT_HEAD      = 2'b00,
        FT_BODY      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_BUSY = 1'b1
    } vc_state_e;

    vc_state_e       state_q [N_VC];
    vc_state_e       state_d [N_VC];
    logic [4:0]      route_q [N_VC];
    logic [4:0]      route_d [N_VC];

    logic            valid_q, valid_d;
    logic [4:0]      port_q,  port_d;
    logic [VC_W-1:0] vc_q,    vc_d;
    logic            err_q,   err_d;

    logic            accept_c;
    logic [4:0]      xy_port_c;

    assign bus.flit_ready_o = !valid_q || bus.route_ready_i;
    assign accept_c         = bus.flit_valid_i && bus.flit_ready_o;

    // Dimension-ordered route: X is resolved before Y
    always_comb begin
        xy_port_c = P_LOCAL;
        if (bus.flit_x_dst_i > X_W'(LOCAL_X))
            xy_port_c = P_EAST;
        else if (bus.flit_x_dst_i < X_W'(LOCAL_X))
            xy_port_c = P_WEST;
        else if (bus.flit_y_dst_i > Y_W'(LOCAL_Y))
            xy_port_c = P_NORTH;
        else if (bus.flit_y_dst_i < Y_W'(LOCAL_Y))
            xy_port_c = P_SOUTH;
    end

    // Per-VC packet state and the output stage contents for the next cycle
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        valid_d = valid_q && !bus.route_ready_i;
        port_d  = port_q;
        vc_d    = vc_q;
        err_d   = err_q;

        if (accept_c) begin
            valid_d = 1'b1;
            vc_d    = bus.flit_vc_i;
            err_d   = 1'b1;     // stays set if the VC id matches no channel
            port_d  = '0;
            for (int v = 0; v < int'(N_VC); v++) begin
                if (bus.flit_vc_i == VC_W'(v)) begin
                    err_d = 1'b0;
                    case (flit_type_e'(bus.flit_type_i))
                        FT_HEAD: begin
                            // A HEAD inside a packet is flagged but still opens the new packet
                            route_d[v] = xy_port_c;
                            state_d[v] = VC_BUSY;
                            if (state_q[v] == VC_BUSY) err_d  = 1'b1;
                            else                       port_d = xy_port_c;
                        end
                        FT_HEAD_TAIL: begin
                            state_d[v] = VC_IDLE;
                            if (state_q[v] == VC_BUSY) err_d  = 1'b1;
                            else                       port_d = xy_port_c;
                        end
                        FT_BODY: begin
                            if (state_q[v] == VC_BUSY) port_d = route_q[v];
                            else                       err_d  = 1'b1;
                        end
                        FT_TAIL: begin
                            state_d[v] = VC_IDLE;
                            if (state_q[v] == VC_BUSY) port_d = route_q[v];
                            else                       err_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            for (int v = 0; v < int'(N_VC); v++) begin
                state_q[v] <= VC_IDLE;
                route_q[v] <= '0;
            end
            valid_q <= 1'b0;
            port_q  <= '0;
            vc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            valid_q <= valid_d;
            port_q  <= port_d;
            vc_q    <= vc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.vc_busy_o = '0;
        for (int v = 0; v < int'(N_VC); v++)
            bus.vc_busy_o[v] = (state_q[v] == VC_BUSY);
    end

    assign bus.route_valid_o = valid_q;
    assign bus.router_port_o = port_q;
    assign bus.route_vc_o    = vc_q;
    assign bus.route_err_o   = err_q;

endmodule

// File: tb/tb_input_router_xy_vc.sv
// Bench for input_router_xy_vc: directed scenarios then random traffic,
// all compared against a packet-level reference model.
module tb_input_router_xy_vc;
    localparam int X_W  = 2;
    localparam int Y_W  = 2;
    localparam int N_VC = 3;
    localparam int VC_W = 2;
    localparam int LX   = 1;
    localparam int LY   = 1;

    localparam int HEAD = 0;
    localparam int BODY = 1;
    localparam int TAIL = 2;
    localparam int HT   = 3;

    logic clk;
    logic arst;

    input_router_xy_vc_if #(.X_W(X_W), .Y_W(Y_W), .N_VC(N_VC)) bus ();

    input_router_xy_vc #(
        .X_W(X_W), .Y_W(Y_W), .N_VC(N_VC), .LOCAL_X(LX), .LOCAL_Y(LY)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what each VC's current packet looks like, and what
    // the single output slot is presenting
    bit         m_busy  [N_VC];
    logic [4:0] m_route [N_VC];
    bit         m_valid;
    logic [4:0] m_port;
    int         m_vc;
    bit         m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] xy_of(input int x, input int y);
        if (x > LX) return 5'b10000;
        if (x < LX) return 5'b01000;
        if (y > LY) return 5'b00010;
        if (y < LY) return 5'b00100;
        return 5'b00001;
    endfunction

    task automatic model_step(input bit rst, input bit fv, input int ft, input int vc,
                              input int x, input int y, input bit rr);
        bit acc;
        acc = fv && (!m_valid || rr);
        if (rst) begin
            for (int i = 0; i < N_VC; i++) begin
                m_busy[i]  = 1'b0;
                m_route[i] = '0;
            end
            m_valid = 1'b0;
            m_port  = '0;
            m_vc    = 0;
            m_err   = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_vc    = vc;
            m_err   = 1'b0;
            m_port  = '0;
            if (vc >= N_VC) begin
                m_err = 1'b1;
            end else if (ft == HEAD || ft == HT) begin
                // A head inside a packet is a protocol error; old packet is abandoned
                if (m_busy[vc]) m_err = 1'b1;
                else            m_port = xy_of(x, y);
                m_busy[vc]  = (ft == HEAD);
                if (ft == HEAD) m_route[vc] = xy_of(x, y);
            end else begin
                if (m_busy[vc]) m_port = m_route[vc];
                else            m_err  = 1'b1;
                if (ft == TAIL) m_busy[vc] = 1'b0;
            end
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: drive inputs from a negedge, check ready, advance model, check outputs
    task automatic cycle(input bit rst, input bit fv, input int ft, input int vc,
                         input int x, input int y, input bit rr);
        logic [N_VC-1:0] eb;
        arst              = !rst;
        bus.flit_valid_i  = fv;
        bus.flit_type_i   = 2'(ft);
        bus.flit_vc_i     = VC_W'(vc);
        bus.flit_x_dst_i  = X_W'(x);
        bus.flit_y_dst_i  = Y_W'(y);
        bus.route_ready_i = rr;
        #1;
        if (!rst) chk("flit_ready", 32'(bus.flit_ready_o), 32'(!m_valid || rr));
        model_step(rst, fv, ft, vc, x, y, rr);
        @(negedge clk);
        chk("route_valid", 32'(bus.route_valid_o), 32'(m_valid));
        if (m_valid) begin
            chk("router_port", 32'(bus.router_port_o), 32'(m_port));
            chk("route_vc",    32'(bus.route_vc_o),    32'(m_vc));
            chk("route_err",   32'(bus.route_err_o),   32'(m_err));
        end
        for (int i = 0; i < N_VC; i++) eb[i] = m_busy[i];
        chk("vc_busy", 32'(bus.vc_busy_o), 32'(eb));
    endtask

    initial begin
        arst              = 1'b0;
        bus.flit_valid_i  = 1'b0;
        bus.flit_type_i   = '0;
        bus.flit_vc_i     = '0;
        bus.flit_x_dst_i  = '0;
        bus.flit_y_dst_i  = '0;
        bus.route_ready_i = 1'b0;
        m_valid           = 1'b0;
        @(negedge clk);

        // Reset held two clocks with a flit offered
        cycle(1, 1, HEAD, 0, 3, 0, 0);
        cycle(1, 1, HEAD, 0, 3, 0, 0);
        chk("rst_valid", 32'(bus.route_valid_o), 32'd0);
        chk("rst_ready", 32'(bus.flit_ready_o),  32'd1);
        chk("rst_busy",  32'(bus.vc_busy_o),     32'd0);
        chk("rst_port",  32'(bus.router_port_o), 32'd0);
        chk("rst_vc",    32'(bus.route_vc_o),    32'd0);
        chk("rst_err",   32'(bus.route_err_o),   32'd0);

        // Full packet east on vc0; body/tail destinations are ignored
        cycle(0, 1, HEAD, 0, 3, 0, 1);
        chk("t2_head_port", 32'(bus.router_port_o), 32'h10);
        chk("t2_busy_set",  32'(bus.vc_busy_o[0]),  32'd1);
        cycle(0, 1, BODY, 0, 0, 0, 1);
        chk("t2_body_port", 32'(bus.router_port_o), 32'h10);
        cycle(0, 1, TAIL, 0, 0, 0, 1);
        chk("t2_tail_port", 32'(bus.router_port_o), 32'h10);
        chk("t2_busy_clr",  32'(bus.vc_busy_o[0]),  32'd0);
        cycle(0, 0, HEAD, 0, 0, 0, 1);

        // Backpressure: north request held, next flit stalled
        cycle(0, 1, HEAD, 0, 1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, BODY, 0, 0, 0, 0);
            chk("t3_hold_port", 32'(bus.router_port_o), 32'h02);
            chk("t3_stall",     32'(bus.flit_ready_o),  32'd0);
        end
        cycle(0, 1, BODY, 0, 0, 0, 1);
        cycle(0, 1, TAIL, 0, 0, 0, 1);
        cycle(0, 0, HEAD, 0, 0, 0, 1);

        // Interleaved packets on two VCs
        cycle(0, 1, HEAD, 0, 0, 1, 1);
        chk("t4_west",  32'(bus.router_port_o), 32'h08);
        cycle(0, 1, HEAD, 1, 1, 1, 1);
        chk("t4_local", 32'(bus.router_port_o), 32'h01);
        cycle(0, 1, BODY, 0, 3, 3, 1);
        chk("t4_body0", 32'(bus.router_port_o), 32'h08);
        cycle(0, 1, TAIL, 1, 3, 3, 1);
        chk("t4_tail1", 32'(bus.router_port_o), 32'h01);
        cycle(0, 1, TAIL, 0, 0, 0, 1);
        cycle(0, 0, HEAD, 0, 0, 0, 1);

        // Protocol errors
        cycle(0, 1, BODY, 1, 0, 0, 1);
        chk("t5_idle_body_err",  32'(bus.route_err_o),   32'd1);
        chk("t5_idle_body_port", 32'(bus.router_port_o), 32'd0);
        cycle(0, 1, HEAD, 0, 2, 1, 1);
        cycle(0, 1, HEAD, 0, 1, 0, 1);
        chk("t5_dup_head_err",  32'(bus.route_err_o),  32'd1);
        chk("t5_dup_head_busy", 32'(bus.vc_busy_o[0]), 32'd1);
        cycle(0, 1, BODY, 0, 0, 0, 1);
        chk("t5_new_route", 32'(bus.router_port_o), 32'h04);
        cycle(0, 1, HEAD, 3, 2, 2, 1);
        chk("t5_bad_vc_err",  32'(bus.route_err_o), 32'd1);
        chk("t5_bad_vc_busy", 32'(bus.vc_busy_o),   32'd1);
        cycle(0, 1, TAIL, 0, 0, 0, 1);
        cycle(0, 0, HEAD, 0, 0, 0, 1);

        // Reset in the middle of a packet
        cycle(0, 1, HEAD, 0, 3, 3, 1);
        cycle(1, 0, HEAD, 0, 0, 0, 1);
        chk("t6_rst_valid", 32'(bus.route_valid_o), 32'd0);
        cycle(0, 1, BODY, 0, 0, 0, 1);
        chk("t6_body_err", 32'(bus.route_err_o), 32'd1);
        cycle(0, 0, HEAD, 0, 0, 0, 1);

        // Random traffic, including illegal VCs, stalls and occasional resets
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
